// File: rtl/hex_display_pkg.sv
// rtl/hex_display_pkg.sv - shared seven-segment types, blank code and hex decoder
package hex_display_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_BLANK = 7'h7F;

  // Active-low gfedcba; every nibble maps to a defined pattern.
  function automatic seg7_t hex_to_seg7(input logic [3:0] nibble);
    seg7_t seg;
    case (nibble)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/hex_display_ctrl_if.sv
// rtl/hex_display_ctrl_if.sv - value load, display options and pin outputs of the display controller
interface hex_display_ctrl_if #(
  parameter int NUM_DIGITS = 4
);

  logic                      load;
  logic [4*NUM_DIGITS-1:0]   value;
  logic                      blank_lz;
  logic [NUM_DIGITS-1:0]     blink_mask;
  logic [7*NUM_DIGITS-1:0]   seg_static;
  logic [6:0]                seg_scan;
  logic [NUM_DIGITS-1:0]     an;

  modport master (
    output load, value, blank_lz, blink_mask,
    input  seg_static, seg_scan, an
  );

  modport slave (
    input  load, value, blank_lz, blink_mask,
    output seg_static, seg_scan, an
  );

endinterface

// File: rtl/hex_digit_mux.sv
// rtl/hex_digit_mux.sv - picks one nibble and its blank flag, emits final active-low segments
module hex_digit_mux
  import hex_display_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic [IDX_W-1:0]        sel,
  output seg7_t                   seg
);

  logic [3:0] nibble;
  logic       blank_sel;

  // Loop compare keeps out-of-range selects harmless for non power-of-two widths.
  always_comb begin
    nibble    = 4'h0;
    blank_sel = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sel == IDX_W'(i)) begin
        nibble    = value[4*i +: 4];
        blank_sel = blank[i];
      end
    end
  end

  assign seg = blank_sel ? SEG_BLANK : hex_to_seg7(nibble);

endmodule

// File: rtl/hex_display_ctrl.sv
// rtl/hex_display_ctrl.sv - multi-digit hex display: static + scanned outputs, blanking; HEX_DISPLAY_BLINK_EN enables blink
module hex_display_ctrl
  import hex_display_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int BLINK_DIV  = 12500000
) (
  input  logic               clk,
  input  logic               reset_n,
  hex_display_ctrl_if.slave  dsp
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SCW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [4*NUM_DIGITS-1:0] value_q;
  logic [IDX_W-1:0]        scan_idx;
  logic [SCW-1:0]          scan_cnt;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic [NUM_DIGITS-1:0]   blink_blank;
  logic [NUM_DIGITS-1:0]   blank_all;
  logic                    zero_above;
  logic [7*NUM_DIGITS-1:0] static_next;
  seg7_t                   scan_next;

  // Walk from the most significant digit down; digit 0 always stays visible.
  always_comb begin
    lz_blank   = '0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above & (value_q[4*i +: 4] == 4'h0);
      if (i != 0) begin
        lz_blank[i] = dsp.blank_lz & zero_above;
      end
    end
  end

`ifdef HEX_DISPLAY_BLINK_EN
  localparam int BCW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BCW-1:0] blink_cnt;
  logic           blink_phase;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BCW'(BLINK_DIV - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + 1'b1;
    end
  end

  assign blink_blank = blink_phase ? dsp.blink_mask : '0;
`else
  logic unused_blink_mask;

  assign unused_blink_mask = ^dsp.blink_mask;
  assign blink_blank       = '0;
`endif

  assign blank_all = lz_blank | blink_blank;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_static
    hex_digit_mux #(
      .NUM_DIGITS (NUM_DIGITS),
      .IDX_W      (IDX_W)
    ) u_static_mux (
      .value (value_q),
      .blank (blank_all),
      .sel   (IDX_W'(g)),
      .seg   (static_next[7*g +: 7])
    );
  end

  hex_digit_mux #(
    .NUM_DIGITS (NUM_DIGITS),
    .IDX_W      (IDX_W)
  ) u_scan_mux (
    .value (value_q),
    .blank (blank_all),
    .sel   (scan_idx),
    .seg   (scan_next)
  );

  // an and seg_scan both follow scan_idx from the same edge, so they never disagree.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value_q        <= '0;
      scan_idx       <= '0;
      scan_cnt       <= '0;
      dsp.seg_static <= '1;
      dsp.seg_scan   <= SEG_BLANK;
      dsp.an         <= '1;
    end else begin
      if (dsp.load) begin
        value_q <= dsp.value;
      end
      if (scan_cnt == SCW'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        scan_idx <= (scan_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      dsp.seg_static <= static_next;
      dsp.seg_scan   <= scan_next;
      dsp.an         <= ~(NUM_DIGITS'(1) << scan_idx);
    end
  end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// tb/tb_hex_display_ctrl.sv - directed and random checks of hex_display_ctrl against an arithmetic display model
module tb_hex_display_ctrl;

  localparam int N  = 4;
  localparam int SD = 2;
  localparam int BD = 4;
`ifdef HEX_DISPLAY_BLINK_EN
  localparam bit BLINK_EN = 1'b1;
`else
  localparam bit BLINK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  hex_display_ctrl_if #(.NUM_DIGITS(N)) dsp_if ();

  hex_display_ctrl #(
    .NUM_DIGITS (N),
    .SCAN_DIV   (SD),
    .BLINK_DIV  (BD)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .dsp     (dsp_if)
  );

  logic [6:0] dec [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] mval;
  int          edges;

  task automatic check(input string tag, input logic [27:0] got, input logic [27:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] exp_digit(input logic [15:0] val, input int i, input logic blz,
                                           input logic [3:0] mask, input int phase);
    logic [15:0] upper;
    upper = val >> (4 * i);
    if ((blz && i != 0 && upper == 16'h0) || (BLINK_EN && phase == 1 && mask[i]))
      return 7'h7F;
    return dec[upper[3:0]];
  endfunction

  // Starts and ends at a falling edge; expectations come from the state before the rising edge.
  task automatic step(input logic ld, input logic [15:0] v, input logic blz, input logic [3:0] mask);
    logic [27:0] es;
    logic [6:0]  esc;
    logic [3:0]  ean;
    int          idx;
    int          ph;
    dsp_if.load       = ld;
    dsp_if.value      = v;
    dsp_if.blank_lz   = blz;
    dsp_if.blink_mask = mask;
    ph  = (edges / BD) % 2;
    idx = (edges / SD) % N;
    for (int i = 0; i < N; i++) es[7*i +: 7] = exp_digit(mval, i, blz, mask, ph);
    esc = exp_digit(mval, idx, blz, mask, ph);
    ean = ~(4'b0001 << idx);
    @(posedge clk);
    if (ld) mval = v;
    edges++;
    @(negedge clk);
    check("seg_static", dsp_if.seg_static, es);
    check("seg_scan", {21'b0, dsp_if.seg_scan}, {21'b0, esc});
    check("an", {24'b0, dsp_if.an}, {24'b0, ean});
  endtask

  initial begin
    logic reached;
    reset_n           = 1'b0;
    dsp_if.load       = 1'b0;
    dsp_if.value      = '0;
    dsp_if.blank_lz   = 1'b0;
    dsp_if.blink_mask = '0;
    mval              = '0;
    edges             = 0;
    repeat (2) @(negedge clk);
    check("reset_static", dsp_if.seg_static, 28'hFFFFFFF);
    check("reset_scan", {21'b0, dsp_if.seg_scan}, 28'h7F);
    check("reset_an", {24'b0, dsp_if.an}, 28'hF);
    reset_n = 1'b1;

    step(1'b0, 16'h0, 1'b0, 4'h0);
    step(1'b0, 16'h0, 1'b0, 4'h0);
    step(1'b1, 16'h1234, 1'b0, 4'h0);
    step(1'b0, 16'hFFFF, 1'b0, 4'h0);
    check("load_1234", dsp_if.seg_static, {7'h79, 7'h24, 7'h30, 7'h19});
    repeat (8) step(1'b0, 16'h0, 1'b0, 4'h0);

    step(1'b1, 16'hABCD, 1'b0, 4'h0);
    repeat (10) step(1'b0, 16'h0, 1'b0, 4'h0);

    step(1'b1, 16'h0005, 1'b1, 4'h0);
    step(1'b0, 16'h0, 1'b1, 4'h0);
    check("lz_0005", dsp_if.seg_static, {7'h7F, 7'h7F, 7'h7F, 7'h12});
    step(1'b1, 16'h0000, 1'b1, 4'h0);
    step(1'b0, 16'h0, 1'b1, 4'h0);
    check("lz_0000", dsp_if.seg_static, {7'h7F, 7'h7F, 7'h7F, 7'h40});
    step(1'b1, 16'h0100, 1'b1, 4'h0);
    step(1'b0, 16'h0, 1'b1, 4'h0);
    check("lz_0100", dsp_if.seg_static, {7'h7F, 7'h79, 7'h40, 7'h40});
    repeat (8) step(1'b0, 16'h0, 1'b1, 4'h0);

    step(1'b1, 16'h0008, 1'b0, 4'b0001);
    repeat (16) step(1'b0, 16'h0, 1'b0, 4'b0001);

    for (int d = 0; d < 16; d++) begin
      step(1'b1, 16'(d), 1'b0, 4'h0);
      step(1'b0, 16'h0, 1'b0, 4'h0);
      check("sweep_digit0", {21'b0, dsp_if.seg_static[6:0]}, {21'b0, dec[d]});
      check("sweep_upper", {7'b0, dsp_if.seg_static[27:7]}, {7'b0, 7'h40, 7'h40, 7'h40});
    end

    repeat (300) step(1'($urandom_range(0, 3) == 0), 16'($urandom), 1'($urandom), 4'($urandom));

    reached = 1'b0;
    for (int t = 0; t < 20 && !reached; t++) begin
      step(1'b0, 16'h0, 1'b0, 4'h0);
      if ((edges / SD) % N == 2) reached = 1'b1;
    end
    check("scan_idx_2_reached", {27'b0, reached}, 28'h1);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_scan", {21'b0, dsp_if.seg_scan}, 28'h7F);
    check("async_reset_an", {24'b0, dsp_if.an}, 28'hF);
    check("async_reset_static", dsp_if.seg_static, 28'hFFFFFFF);
    @(negedge clk);
    reset_n = 1'b1;
    mval    = '0;
    edges   = 0;
    step(1'b0, 16'h0, 1'b0, 4'h0);
    check("restart_an", {24'b0, dsp_if.an}, 28'hE);
    check("restart_scan", {21'b0, dsp_if.seg_scan}, 28'h40);
    repeat (10) step(1'b0, 16'h0, 1'b1, 4'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
